// File: rtl/axi_setting_reg_bank_pkg.sv
// Shared constants and helpers for the settings-bus-to-stream bank.
// Optional macro AXI_SETTING_REG_BANK_OVF_CNT_EN uses OVF_W/OVF_MAX.
package axi_setting_reg_bank_pkg;

  localparam int OVF_W = 8;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_setting_reg_bank_chan_fifo.sv
// One channel: DEPTH x WIDTH FIFO, repeat rule, overflow tracking.
// Ports: clk_i/rst_i, push_i+data_i in, tdata_o/tvalid_o/tready_i
// stream, overflow_o; ovf_cnt_o with AXI_SETTING_REG_BANK_OVF_CNT_EN.
module setting_chan_fifo
  import axi_setting_reg_bank_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 4,
  parameter logic [WIDTH-1:0] DATA_AT_RESET  = '0,
  parameter bit               VALID_AT_RESET = 1'b0,
  parameter bit               REPEATS        = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] tdata_o,
  output logic             tvalid_o,
  input  logic             tready_i,
  output logic             overflow_o
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0] ovf_cnt_o
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, pop, wr_en, drop;

  always_comb begin
    tvalid_o = (cnt_q != '0);
    full     = (cnt_q == FULL);
    // With REPEATS the sole entry survives a handshake unless
    // a new word arrives to replace it.
    pop      = tvalid_o & tready_i &
               ~(REPEATS && (cnt_q == ONE) && !push_i);
    wr_en    = push_i & (~full | pop);
    drop     = push_i & full & ~pop;
    rd_d     = pop   ? rd_q + PW'(1) : rd_q;
    wr_d     = wr_en ? wr_q + PW'(1) : wr_q;
    cnt_d    = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  assign tdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q     <= '0;
      // A preloaded entry occupies slot 0, so writes start at 1.
      wr_q     <= VALID_AT_RESET ? PW'(1) : '0;
      cnt_q    <= VALID_AT_RESET ? ONE : '0;
      mem_q[0] <= DATA_AT_RESET;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[wr_q] <= data_i;
    end
  end

`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ovf_q <= '0;
    else if (drop && ovf_q != OVF_MAX)
      ovf_q <= ovf_q + OVF_W'(1);
  end

  assign ovf_cnt_o  = ovf_q;
  assign overflow_o = (ovf_q != '0);
`else
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
  end

  assign overflow_o = ovf_q;
`endif

endmodule

// File: rtl/axi_setting_reg_bank.sv
// Settings bus to NUM_CH AXI streams, one FIFO per channel.
// Ports: clk/reset, set_stb/set_addr/set_data in, o_tdata/o_tlast/
// o_tvalid/o_tready per channel, overflow sticky flags; ovf_count
// added when AXI_SETTING_REG_BANK_OVF_CNT_EN is defined.
module axi_setting_reg_bank
  import axi_setting_reg_bank_pkg::*;
#(
  parameter int ADDR           = 0,
  parameter int AWIDTH         = 8,
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int DATA_AT_RESET  = 0,
  parameter int VALID_AT_RESET = 0,
  parameter int REPEATS        = 0,
  parameter int MSB_ALIGN      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_stb,
  input  logic [AWIDTH-1:0]       set_addr,
  input  logic [31:0]             set_data,
  output logic [NUM_CH*WIDTH-1:0] o_tdata,
  output logic [NUM_CH-1:0]       o_tlast,
  output logic [NUM_CH-1:0]       o_tvalid,
  input  logic [NUM_CH-1:0]       o_tready,
  output logic [NUM_CH-1:0]       overflow
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
  ,
  output logic [NUM_CH*OVF_W-1:0] ovf_count
`endif
);

  logic [WIDTH-1:0]  wdata;
  logic [NUM_CH-1:0] hit;
  logic              unused_data;

  assign unused_data = ^set_data;
  assign o_tlast     = '0;

  if (MSB_ALIGN != 0) begin : g_msb
    assign wdata = set_data[31 -: WIDTH];
  end else begin : g_lsb
    assign wdata = set_data[WIDTH-1:0];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign hit[c] = set_stb && (set_addr == AWIDTH'(ADDR + c));

    setting_chan_fifo #(
      .WIDTH          (WIDTH),
      .DEPTH          (DEPTH),
      .DATA_AT_RESET  (WIDTH'(DATA_AT_RESET)),
      .VALID_AT_RESET (VALID_AT_RESET != 0),
      .REPEATS        (REPEATS != 0)
    ) u_fifo (
      .clk_i      (clk),
      .rst_i      (reset),
      .push_i     (hit[c]),
      .data_i     (wdata),
      .tdata_o    (o_tdata[c*WIDTH +: WIDTH]),
      .tvalid_o   (o_tvalid[c]),
      .tready_i   (o_tready[c]),
      .overflow_o (overflow[c])
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
      ,
      .ovf_cnt_o  (ovf_count[c*OVF_W +: OVF_W])
`endif
    );
  end

endmodule

// File: tb/tb_axi_setting_reg_bank.sv
// Bench for axi_setting_reg_bank: two configurations vs a queue model.
// Honours AXI_SETTING_REG_BANK_OVF_CNT_EN for the counter outputs.
module tb_axi_setting_reg_bank;

  logic        clk;
  logic        rst;
  logic        stb;
  logic [7:0]  addr;
  logic [31:0] data;

  logic [127:0] tdata_a;
  logic [3:0]   tlast_a, tvalid_a, rdy_a, ovf_a;
  logic [15:0]  tdata_b;
  logic [1:0]   tlast_b, tvalid_b, rdy_b, ovf_b;
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
  logic [31:0]  cnt_a;
  logic [15:0]  cnt_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq [8][$];
  bit          mflag [8];
  int          mcnt  [8];

  axi_setting_reg_bank #(
    .ADDR(16), .AWIDTH(8), .NUM_CH(4), .WIDTH(32), .DEPTH(4),
    .DATA_AT_RESET(32'hA5), .VALID_AT_RESET(1), .REPEATS(0),
    .MSB_ALIGN(0)
  ) dut_a (
    .clk(clk), .reset(rst), .set_stb(stb), .set_addr(addr),
    .set_data(data), .o_tdata(tdata_a), .o_tlast(tlast_a),
    .o_tvalid(tvalid_a), .o_tready(rdy_a), .overflow(ovf_a)
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
    , .ovf_count(cnt_a)
`endif
  );

  axi_setting_reg_bank #(
    .ADDR(0), .AWIDTH(8), .NUM_CH(2), .WIDTH(8), .DEPTH(4),
    .DATA_AT_RESET(0), .VALID_AT_RESET(0), .REPEATS(1),
    .MSB_ALIGN(1)
  ) dut_b (
    .clk(clk), .reset(rst), .set_stb(stb), .set_addr(addr),
    .set_data(data), .o_tdata(tdata_b), .o_tlast(tlast_b),
    .o_tvalid(tvalid_b), .o_tready(rdy_b), .overflow(ovf_b)
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
    , .ovf_count(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int base(input int d);
    return (d == 0) ? 16 : 0;
  endfunction

  function automatic logic [31:0] align(input int d,
                                        input logic [31:0] v);
    return (d == 0) ? v : {24'd0, v[31:24]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mq[i].delete();
      mflag[i] = 1'b0;
      mcnt[i]  = 0;
    end
    for (int c = 0; c < 4; c++) mq[c].push_back(32'hA5);
  endtask

  task automatic model_update();
    int  i, n;
    bit  hit, rdy, pop;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < nch(d); c++) begin
        i   = d * 4 + c;
        n   = mq[i].size();
        hit = stb && (int'(addr) == base(d) + c);
        rdy = (d == 0) ? rdy_a[c] : rdy_b[c];
        pop = (n > 0) && rdy;
        if (d == 1 && n == 1 && !hit) pop = 1'b0;
        if (pop) void'(mq[i].pop_front());
        if (hit) begin
          if (n < 4 || pop) begin
            mq[i].push_back(align(d, data));
          end else begin
            mflag[i] = 1'b1;
            if (mcnt[i] < 255) mcnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("A.valid%0d", c), 32'(tvalid_a[c]),
          32'(mq[c].size() != 0));
      if (mq[c].size() != 0)
        chk($sformatf("A.data%0d", c), tdata_a[c*32 +: 32], mq[c][0]);
      chk($sformatf("A.ovf%0d", c), 32'(ovf_a[c]), 32'(mflag[c]));
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
      chk($sformatf("A.cnt%0d", c), 32'(cnt_a[c*8 +: 8]), mcnt[c]);
`endif
    end
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("B.valid%0d", c), 32'(tvalid_b[c]),
          32'(mq[4+c].size() != 0));
      if (mq[4+c].size() != 0)
        chk($sformatf("B.data%0d", c), 32'(tdata_b[c*8 +: 8]),
            mq[4+c][0]);
      chk($sformatf("B.ovf%0d", c), 32'(ovf_b[c]), 32'(mflag[4+c]));
`ifdef AXI_SETTING_REG_BANK_OVF_CNT_EN
      chk($sformatf("B.cnt%0d", c), 32'(cnt_b[c*8 +: 8]), mcnt[4+c]);
`endif
    end
    chk("tlast", {26'd0, tlast_b, tlast_a}, 32'd0);
  endtask

  task automatic step();
    if (rst) model_reset();
    else     model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    stb  = 1'b1;
    addr = a;
    data = v;
    step();
    stb  = 1'b0;
  endtask

  initial begin
    int r;
    rst   = 1'b1;
    stb   = 1'b0;
    addr  = '0;
    data  = '0;
    rdy_a = '0;
    rdy_b = '0;
    step();
    step();
    rst = 1'b0;
    step();
    rdy_a = 4'b0001;
    step();
    rdy_a = '0;
    step();

    wr(8'h12, 32'd1);
    wr(8'h12, 32'd2);
    wr(8'h12, 32'd3);
    rdy_a = 4'hF;
    repeat (4) step();
    rdy_a = '0;
    wr(8'h14, 32'h99);
    step();

    for (int v = 1; v <= 5; v++) wr(8'h11, 32'(v));
    rdy_a = 4'b0010;
    wr(8'h11, 32'd6);
    repeat (5) step();
    rdy_a = '0;

    rdy_b = 2'b11;
    wr(8'h00, 32'h7700_0000);
    repeat (12) step();
    wr(8'h00, 32'h8800_0000);
    repeat (5) step();
    rdy_b = '0;

    wr(8'h01, 32'hDEAD_BEEF);
    wr(8'h10, 32'hDEAD_BEEF);
    step();

    wr(8'h13, 32'h31);
    wr(8'h13, 32'h32);
    wr(8'h13, 32'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr(8'h13, 32'h55);
    step();

    repeat (3000) begin
      rst = ($urandom_range(0, 499) == 0);
      stb = ($urandom_range(0, 1) == 1);
      r   = int'($urandom_range(0, 7));
      if (r < 3)      addr = 8'(r);
      else if (r < 7) addr = 8'(16 + r - 3);
      else            addr = 8'($urandom_range(0, 255));
      data = $urandom;
      for (int c = 0; c < 4; c++)
        rdy_a[c] = ($urandom_range(0, 9) < 3);
      for (int c = 0; c < 2; c++)
        rdy_b[c] = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
